// File: rtl/fsm_1101.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_1101
//  Purpose  : Mealy serial sequence detector for the pattern 1-1-0-1,
//             overlapping occurrences included. One bit is consumed on
//             every rising clock edge; the detection strobe is asserted
//             combinationally in the same cycle the completing '1' is
//             present on the input.
//  Ports    : clk  - system clock, rising-edge active
//             rst  - asynchronous, active-high reset (state -> S0)
//             in   - serial data bit
//             out  - detection strobe (state == S3 and in == 1)
//  Revision : 1.0 - initial release
// ============================================================================
module fsm_1101 (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  // Binary encoding is fixed so that `state` can be probed hierarchically
  // and interpreted as "number of pattern bits matched so far".
  typedef enum logic [1:0] {
    S0 = 2'd0,  // nothing matched
    S1 = 2'd1,  // "1"
    S2 = 2'd2,  // "11"
    S3 = 2'd3   // "110"
  } state_t;

  state_t state;
  state_t state_d;

  // Next-state logic. Each transition lands on the longest suffix of the
  // bits seen so far that is still a prefix of 1101, which is what makes
  // overlapping matches fall out naturally.
  always_comb begin
    state_d = S0;
    case (state)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S2 : S0;
      // A run of ones keeps the "11" prefix alive.
      S2:      state_d = in ? S2 : S3;
      // The terminal '1' of a match is itself the first '1' of the next one.
      S3:      state_d = in ? S1 : S0;
      // Any corrupted value recovers to idle on the next edge.
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_d;
    end
  end

  // Mealy strobe: zero-latency, valid while the completing bit is applied.
  assign out = (state == S3) && in;

endmodule
`default_nettype wire

// File: tb/tb_fsm_1101.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_1101
//  Purpose  : Self-checking bench for fsm_1101. A history-based reference
//             (last bits seen since reset, matched against the pattern)
//             predicts state and strobe every cycle; directed sequences
//             with hand-written expectations pin that reference down.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_1101;

  logic clk;
  logic rst;
  logic din;
  logic dout;

  int checks = 0;
  int errors = 0;

  fsm_1101 dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference: remember the most recent bits consumed since reset.
  // --------------------------------------------------------------------------
  int pat [4] = '{1, 1, 0, 1};
  logic [3:0] hist = 4'd0;  // hist[0] = newest consumed bit
  int hlen = 0;             // bits consumed since reset, saturating at 4

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 4'd0;
      hlen <= 0;
    end else begin
      hist <= {hist[2:0], din};
      hlen <= (hlen < 4) ? hlen + 1 : 4;
    end
  end

  // True when the last k consumed bits equal the first k pattern bits.
  function automatic bit tail_matches(input int k);
    if (hlen < k) return 1'b0;
    for (int j = 0; j < k; j++) begin
      if (int'(hist[k-1-j]) != pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Progress = longest proper prefix of the pattern that ends the history.
  function automatic int exp_state();
    for (int k = 3; k >= 1; k--) begin
      if (tail_matches(k)) return k;
    end
    return 0;
  endfunction

  function automatic logic exp_out();
    return tail_matches(3) && (din == 1'b1);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference, away from the clock edge.
  always @(negedge clk) begin
    logic [1:0] st;
    st = dut.state;
    chk("model_state", (^st === 1'bx) ? -1 : int'(st), exp_state());
    chk("model_out", (dout === 1'bx) ? -1 : int'(dout), int'(exp_out()));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus helpers
  // --------------------------------------------------------------------------
  logic sample_out;
  logic [1:0] sample_st;

  // Present one bit for the coming edge and sample outputs mid-cycle.
  task automatic apply(input logic b);
    @(posedge clk);
    #1 din = b;
    #2;
    sample_out = dout;
    sample_st  = dut.state;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 din = ~din;
      #2;
      chk("rst_state", int'(dut.state), 0);
      chk("rst_out", int'(dout), 0);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    din = 1'b0;
  endtask

  int qb [$];
  int qs [$];
  int qo [$];

  task automatic run_seq(input string nm, input int final_st, input int n_strobes);
    int strobes;
    strobes = 0;
    for (int i = 0; i < qb.size(); i++) begin
      apply(qb[i][0]);
      chk({nm, "_state"}, int'(sample_st), qs[i]);
      chk({nm, "_out"}, int'(sample_out), qo[i]);
      if (sample_out === 1'b1) strobes++;
    end
    @(posedge clk);
    #3;
    chk({nm, "_final"}, int'(dut.state), final_st);
    chk({nm, "_strobes"}, strobes, n_strobes);
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    #12;
    rst = 1'b0;

    do_reset();
    qb = '{0, 1, 1, 0, 1, 1, 1};
    qs = '{0, 0, 1, 2, 3, 1, 2};
    qo = '{0, 0, 0, 0, 1, 0, 0};
    run_seq("basic", 2, 1);

    do_reset();
    qb = '{1, 1, 0, 1, 1, 0, 1};
    qs = '{0, 1, 2, 3, 1, 2, 3};
    qo = '{0, 0, 0, 1, 0, 0, 1};
    run_seq("overlap", 1, 2);

    do_reset();
    qb = '{1, 1, 1, 1, 0, 1};
    qs = '{0, 1, 2, 2, 2, 3};
    qo = '{0, 0, 0, 0, 0, 1};
    run_seq("ones", 1, 1);

    do_reset();
    qb = '{1, 0, 1, 0, 1, 1, 0, 0, 1};
    qs = '{0, 1, 0, 1, 0, 1, 2, 3, 0};
    qo = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("near", 1, 0);

    // Asynchronous reset in the middle of a partial match.
    do_reset();
    apply(1'b1);
    apply(1'b1);
    apply(1'b0);
    @(posedge clk);
    #1;
    chk("async_pre_state", int'(dut.state), 3);
    rst = 1'b1;
    #1;
    chk("async_state", int'(dut.state), 0);
    chk("async_out", int'(dout), 0);
    #1 rst = 1'b0;
    apply(1'b1);
    chk("async_next_out", int'(sample_out), 0);
    @(posedge clk);
    #3;
    chk("async_next_state", int'(dut.state), 1);

    // Random stream with occasional mid-cycle reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1 din = ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
